// File: rtl/hrange_arbiter.sv
// Round-robin arbiter sharing one range generator between two requesters.
// Routes generator values to the granted requester; aborts runs that stay silent for TIMEOUT cycles.
module hrange_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    req0_start,
  input  logic signed [WIDTH-1:0] req0_base,
  input  logic signed [WIDTH-1:0] req0_limit,
  input  logic signed [WIDTH-1:0] req0_step,
  output logic                    req0_busy,
  output logic signed [WIDTH-1:0] req0_0,
  output logic                    req0_valid,
  output logic                    req0_ready,
  output logic                    req0_err,
  input  logic                    req1_start,
  input  logic signed [WIDTH-1:0] req1_base,
  input  logic signed [WIDTH-1:0] req1_limit,
  input  logic signed [WIDTH-1:0] req1_step,
  output logic                    req1_busy,
  output logic signed [WIDTH-1:0] req1_0,
  output logic                    req1_valid,
  output logic                    req1_ready,
  output logic                    req1_err,
  output logic                    gen_start,
  output logic signed [WIDTH-1:0] gen_base,
  output logic signed [WIDTH-1:0] gen_limit,
  output logic signed [WIDTH-1:0] gen_step,
  output logic                    gen_reset,
  input  logic signed [WIDTH-1:0] gen_0,
  input  logic                    gen_valid,
  input  logic                    gen_ready
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

  // Abort fires on the silent cycle that would bring the counter to TIMEOUT.
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  state_t                  state;
  logic [1:0]              pending;
  logic [1:0]              start_v;
  logic [1:0]              valid_q;
  logic [1:0]              ready_q;
  logic [1:0]              err_q;
  logic                    last_grant;
  logic                    grant;
  logic                    pick;
  logic [15:0]             idle_cnt;
  logic signed [WIDTH-1:0] base_in  [2];
  logic signed [WIDTH-1:0] limit_in [2];
  logic signed [WIDTH-1:0] step_in  [2];
  logic signed [WIDTH-1:0] base_q   [2];
  logic signed [WIDTH-1:0] limit_q  [2];
  logic signed [WIDTH-1:0] step_q   [2];
  logic signed [WIDTH-1:0] out_q    [2];

  assign start_v     = {req1_start, req0_start};
  assign base_in[0]  = req0_base;
  assign base_in[1]  = req1_base;
  assign limit_in[0] = req0_limit;
  assign limit_in[1] = req1_limit;
  assign step_in[0]  = req0_step;
  assign step_in[1]  = req1_step;

  // With both pending, the requester not served last wins.
  assign pick = (&pending) ? ~last_grant : pending[1];

  assign req0_busy  = pending[0];
  assign req1_busy  = pending[1];
  assign req0_0     = out_q[0];
  assign req1_0     = out_q[1];
  assign req0_valid = valid_q[0];
  assign req1_valid = valid_q[1];
  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];

  // NOTE: argument holding registers carry no reset; they are only read after a capture wrote them.
  always_ff @(posedge _clock) begin
    for (int i = 0; i < 2; i++) begin
      if (start_v[i] && !pending[i]) begin
        base_q[i]  <= base_in[i];
        limit_q[i] <= limit_in[i];
        step_q[i]  <= step_in[i];
      end
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state      <= IDLE;
      pending    <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      idle_cnt   <= '0;
      gen_start  <= 1'b0;
      gen_reset  <= 1'b0;
      gen_base   <= '0;
      gen_limit  <= '0;
      gen_step   <= '0;
      valid_q    <= '0;
      ready_q    <= '0;
      err_q      <= '0;
      out_q[0]   <= '0;
      out_q[1]   <= '0;
    end else begin
      // NOTE: strobes default low here; later non-blocking assignments in this block override them.
      gen_start <= 1'b0;
      gen_reset <= 1'b0;
      valid_q   <= '0;
      ready_q   <= '0;
      err_q     <= '0;
      out_q[0]  <= '0;
      out_q[1]  <= '0;
      pending   <= pending | start_v;

      case (state)
        IDLE: begin
          if (|pending) begin
            grant     <= pick;
            gen_base  <= base_q[pick];
            gen_limit <= limit_q[pick];
            gen_step  <= step_q[pick];
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          gen_start <= 1'b1;
          idle_cnt  <= '0;
          state     <= RUN;
        end
        RUN: begin
          if (gen_valid) begin
            valid_q[grant] <= 1'b1;
            out_q[grant]   <= gen_0;
          end
          if (gen_valid || gen_ready) idle_cnt <= '0;
          if (gen_ready) begin
            ready_q[grant] <= 1'b1;
            pending[grant] <= 1'b0;
            last_grant     <= grant;
            state          <= IDLE;
          end else if (!gen_valid) begin
            if (idle_cnt == IDLE_LAST) begin
              ready_q[grant] <= 1'b1;
              err_q[grant]   <= 1'b1;
              gen_reset      <= 1'b1;
              pending[grant] <= 1'b0;
              last_grant     <= grant;
              state          <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
